// File: rtl/word_burst_loader_pkg.sv
// Shared types and widths for the word burst loader: FSM state encoding and data widths.
package word_burst_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_WAIT,
    ST_START,
    ST_GAP,
    ST_STREAM,
    ST_DONE
  } state_e;

endpackage : word_burst_loader_pkg

// File: rtl/frame_buffer_ram.sv
// Single-clock simple dual-port frame buffer: synchronous write, registered synchronous read.
module frame_buffer_ram
  import word_burst_loader_pkg::*;
#(
  parameter int N_WORDS = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [N_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; the read register is left
  // unreset too, and the top level masks it to zero whenever it is not streaming.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : frame_buffer_ram

// File: rtl/word_burst_loader.sv
// Packs host bytes into 16-bit words, buffers one frame, then replays it as a
// gap-free burst framed by data_write_start / data_write_done.
module word_burst_loader
  import word_burst_loader_pkg::*;
#(
  parameter int N_WORDS = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              sink_idle,
  output logic [WORD_W-1:0] com_data_in,
  output logic              data_write_start,
  output logic              data_write_done,
  output logic              frame_ready,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_e            state_q, state_d;
  logic              hi_pend_q, hi_pend_d;
  logic [BYTE_W-1:0] hi_byte_q, hi_byte_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              overrun_q, overrun_d;

  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  frame_buffer_ram #(
    .N_WORDS (N_WORDS),
    .ADDR_W  (ADDR_W)
  ) u_frame_buffer_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({hi_byte_q, rx_data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FILL;
      hi_pend_q <= 1'b0;
      hi_byte_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_pend_q <= hi_pend_d;
      hi_byte_q <= hi_byte_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d          = state_q;
    hi_pend_d        = hi_pend_q;
    hi_byte_d        = hi_byte_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    overrun_d        = overrun_q | (rx_valid && (state_q != ST_FILL));
    ram_we           = 1'b0;
    com_data_in      = '0;
    data_write_start = 1'b0;
    data_write_done  = 1'b0;
    frame_ready      = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (rx_valid) begin
          if (!hi_pend_q) begin
            hi_byte_d = rx_data;
            hi_pend_d = 1'b1;
          end else begin
            ram_we    = 1'b1;
            hi_pend_d = 1'b0;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        frame_ready = 1'b1;
        if (sink_idle) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        data_write_start = 1'b1;
        rd_ptr_d         = '0;
        state_d          = ST_GAP;
      end

      ST_GAP: begin
        rd_ptr_d = ADDR_W'(1);
        state_d  = ST_STREAM;
      end

      // rd_ptr_q runs one ahead of the word on the bus, so it wraps to 0 on the last word.
      ST_STREAM: begin
        com_data_in = ram_rdata;
        rd_ptr_d    = rd_ptr_q + 1'b1;
        if (rd_ptr_q == '0) begin
          data_write_done = 1'b1;
          state_d         = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_FILL;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  assign overrun = overrun_q;

endmodule : word_burst_loader

// File: tb/tb_word_burst_loader.sv
// Directed self-checking bench for word_burst_loader: fill, burst timing, overrun,
// asynchronous reset mid-burst and back-to-back frames.
module tb_word_burst_loader;

  localparam int N_WORDS = 1024;
  localparam int ADDR_W  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        sink_idle = 1'b0;
  logic [15:0] com_data_in;
  logic        data_write_start;
  logic        data_write_done;
  logic        frame_ready;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_burst_loader #(
    .N_WORDS (N_WORDS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .sink_idle        (sink_idle),
    .com_data_in      (com_data_in),
    .data_write_start (data_write_start),
    .data_write_done  (data_write_done),
    .frame_ready      (frame_ready),
    .overrun          (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat_word(input int p, input int k);
    case (p)
      0:       return 16'(k * 3);
      1:       return 16'hA5A5;
      2:       return 16'(k) ^ 16'h5A00;
      3:       return ~16'(k);
      default: return 16'(k * 7 + 16'h1234);
    endcase
  endfunction

  // One byte per cycle, high byte first; returns at the negedge after the final byte's edge.
  task automatic fill_frame(input int p);
    logic [15:0] w;
    for (int k = 0; k < N_WORDS; k++) begin
      w = pat_word(p, k);
      @(negedge clk);
      rx_data  = w[15:8];
      rx_valid = 1'b1;
      @(negedge clk);
      if (k == N_WORDS - 1) check("frame_ready_before_last", frame_ready, 0);
      rx_data = w[7:0];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Follows one burst cycle by cycle; optional byte injection or reset at a stream index.
  task automatic run_burst(input int p, input int inject_k, input int abort_k, input bit keep_idle);
    bit found = 1'b0;
    int data_err = 0;
    int done_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (data_write_start) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("start_seen", found, 1);
    if (!found) return;
    check("start_cycle_ready_data", {frame_ready, data_write_done, com_data_in}, 0);
    @(negedge clk);
    sink_idle = keep_idle;
    check("gap_cycle", {data_write_start, data_write_done, com_data_in}, 0);
    for (int k = 0; k < N_WORDS; k++) begin
      @(negedge clk);
      if (com_data_in !== pat_word(p, k)) begin
        if (data_err == 0)
          $display("FAIL burst_word[%0d]: got 0x%0h expected 0x%0h", k, com_data_in, pat_word(p, k));
        data_err++;
      end
      if (data_write_done !== (k == N_WORDS - 1) || data_write_start !== 1'b0) done_err++;
      if (k == abort_k) begin
        #1 rst = 1'b1;
        #1 check("rst_async_outputs",
                 {data_write_start, data_write_done, frame_ready, overrun, com_data_in}, 0);
        return;
      end
      if (k == inject_k) begin
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
    end
    check("burst_data_errors", data_err, 0);
    check("burst_strobe_errors", done_err, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("done_cycle", {data_write_start, data_write_done, com_data_in}, 0);
  endtask

  initial begin
    int bad;
    #1 check("reset_outputs",
             {data_write_start, data_write_done, frame_ready, overrun, com_data_in}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill with sink_idle low: frame_ready rises, no burst starts.
    fill_frame(0);
    check("frame_ready_after_fill", frame_ready, 1);
    check("no_overrun_after_fill", overrun, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_write_start || !frame_ready) bad++;
    end
    check("held_in_wait", bad, 0);

    // Byte in WAIT is dropped and flags overrun.
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("overrun_from_wait", overrun, 1);
    check("ready_kept_after_drop", frame_ready, 1);

    // Burst with a byte injected mid-stream; data must be unchanged.
    sink_idle = 1'b1;
    run_burst(0, 500, -1, 1'b1);
    check("overrun_sticky", overrun, 1);
    sink_idle = 1'b0;

    // Reset at T+100 (stream word 98).
    fill_frame(2);
    sink_idle = 1'b1;
    run_burst(2, -1, 98, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (data_write_start || data_write_done || frame_ready || overrun || com_data_in != 0) bad++;
    end
    check("quiet_after_abort", bad, 0);

    // Refill with 0xA5A5; sink_idle drops during the burst without stalling it.
    fill_frame(1);
    sink_idle = 1'b1;
    run_burst(1, -1, -1, 1'b0);

    // Back-to-back frames with sink_idle held high.
    sink_idle = 1'b1;
    fill_frame(3);
    run_burst(3, -1, -1, 1'b1);
    fill_frame(4);
    run_burst(4, -1, -1, 1'b1);
    check("no_overrun_back_to_back", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_word_burst_loader
